f32_normalizer: RTL and testbench
=================================

F32_NORMALIZER -- requirements
Module: f32_normalizer

Interface
REQ-001 Parameter EW, default 8: exponent width.
REQ-002 Parameter MW, default 23: stored fraction width (hidden bit excluded).
REQ-003 CLK  in  1: sole clock; all state updates on rising edge.
REQ-004 RST_N  in  1: asynchronous, active-low reset.
REQ-005 IN_VALID  in  1: raw-sum input qualifier.
REQ-006 IN_READY  out  1: block accepts input; high only in IDLE.
REQ-007 IN_SIGN  in  1: sign of the raw sum.
REQ-008 IN_EXP  in  EW: biased exponent of the larger operand.
REQ-009 IN_MANT  in  MW+2: raw adder mantissa; bit MW+1 = carry-out, bit MW = hidden bit.
REQ-010 OUT_VALID  out  1: packed result valid.
REQ-011 OUT_READY  in  1: consumer accepts result.
REQ-012 R  out  1+EW+MW: packed result {sign, exp, fraction}.
REQ-013 OVERFLOW  out  1: result saturated to infinity.
REQ-014 UNDERFLOW  out  1: result flushed to zero.

Function
REQ-015 FSM states: IDLE, NORM, DONE.
REQ-016 IDLE: on IN_VALID && IN_READY, the block SHALL register sign, exponent and mantissa, and go to NORM.
REQ-017 NORM evaluates the registers once per cycle, first match wins:
- IN_EXP captured as all-ones -> DONE with OVERFLOW.
- mantissa == 0 -> DONE, R = 0 (sign forced to 0).
- carry bit set -> shift right 1 (bit 0 truncated), exp + 1; new exp == all-ones -> OVERFLOW; else normal; -> DONE.
- hidden bit set -> DONE, normal.
- exp <= 1 -> DONE with UNDERFLOW.
- else shift left 1, exp - 1, stay in NORM.
REQ-018 A 5-bit shift counter SHALL increment per left shift, clear on capture, and force DONE with UNDERFLOW on reaching MW+1.
REQ-019 Rounding SHALL be truncation; no guard or sticky bits.
REQ-020 OVERFLOW result SHALL be {sign, all-ones, 0}; UNDERFLOW result SHALL be {sign, 0, 0}.
REQ-021 A normal result SHALL be {sign, exp, mantissa[MW-1:0]}.
REQ-022 Latency: OUT_VALID SHALL rise 2+k cycles after the accepting edge, where k = number of left shifts.
REQ-023 DONE: OUT_VALID = 1; R, OVERFLOW and UNDERFLOW SHALL stay stable until OUT_READY is sampled high, then the FSM returns to IDLE.
REQ-024 Flags and R SHALL be registered and change only on entry to DONE.
REQ-025 OUT_VALID and IN_READY are never high together; no new input is accepted in the handshake cycle.
REQ-026 IN_VALID outside IDLE SHALL be ignored, and inputs are not sampled.

Reset
REQ-027 On RST_N low: state = IDLE, R = 0, OUT_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0, counter = 0, IN_READY = 1.
REQ-028 Reset asserted in NORM or DONE SHALL discard the in-flight operation with no output produced.

Structure
REQ-029 Shared package f32_pkg SHALL hold EW, MW, BIAS = 127, EXP_MAX = all-ones, the field-position constants and the state enum.
REQ-030 One combinational sub-module f32_pack SHALL assemble R and the flags from sign, exponent, mantissa and the overflow/underflow/zero selects.

Verification
REQ-031 IN_EXP=8'h7F, IN_MANT=25'h0800000, sign 0 -> R=32'h3F800000, no flags, OUT_VALID 2 cycles after accept.
REQ-032 IN_EXP=8'h7F, IN_MANT=25'h1000000 -> R=32'h40000000 after 2 cycles.
REQ-033 IN_EXP=8'h80, IN_MANT=25'h0200000 -> 2 shifts, R=32'h3F000000, OUT_VALID 4 cycles after accept.
REQ-034 IN_EXP=8'hFE, IN_MANT=25'h1000000, sign 1 -> R=32'hFF800000, OVERFLOW=1.
REQ-035 IN_EXP=8'h02, IN_MANT=25'h0000001 -> R=32'h00000000, UNDERFLOW=1; then IN_MANT=0, sign 1 -> R=32'h00000000, no flags.
REQ-036 Backpressure and reset:
- OUT_READY low 5 cycles with IN_VALID high -> R stable and IN_READY=0 throughout.
- RST_N pulsed low during NORM -> IDLE, OUT_VALID=0, IN_READY=1 next cycle.

Source files
------------

// File: rtl/f32_pkg.sv
// f32 normalizer shared package: format widths, field positions,
// exponent constants and the normalizer FSM state encoding.
package f32_pkg;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int BIAS = 127;
  localparam logic [EW-1:0] EXP_MAX = '1;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB = MW;
  localparam int SIGN_POS = EW + MW;
  localparam int HID_POS = MW;
  localparam int CRY_POS = MW + 1;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/f32_pack.sv
// Result packer: builds {sign, exp, frac} and the overflow/underflow
// flags from the normal fields and the ovf/unf/zero selects.
module f32_pack #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic          sign_i,
  input  logic [EW-1:0] exp_i,
  input  logic [MW-1:0] frac_i,
  input  logic          ovf_sel_i,
  input  logic          unf_sel_i,
  input  logic          zero_sel_i,
  output logic [EW+MW:0] r_o,
  output logic          ovf_o,
  output logic          unf_o
);

  always_comb begin
    r_o = {sign_i, exp_i, frac_i};
    ovf_o = 1'b0;
    unf_o = 1'b0;
    unique case (1'b1)
      ovf_sel_i: begin
        r_o = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
        ovf_o = 1'b1;
      end
      unf_sel_i: begin
        r_o = {sign_i, {(EW+MW){1'b0}}};
        unf_o = 1'b1;
      end
      // an exact zero is always +0
      zero_sel_i: r_o = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/f32_normalizer.sv
// Normalizes a raw adder sum into a packed float, one shift per cycle.
// Ports: IN_* valid/ready input, OUT_* valid/ready result, R, flags.
module f32_normalizer #(
  parameter int EW = f32_pkg::EW,
  parameter int MW = f32_pkg::MW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          IN_SIGN,
  input  logic [EW-1:0] IN_EXP,
  input  logic [MW+1:0] IN_MANT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [EW+MW:0] R,
  output logic          OVERFLOW,
  output logic          UNDERFLOW
);

  import f32_pkg::*;

  localparam logic [EW-1:0] EMAX = {EW{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MW + 1);

  state_e state_q, state_d;
  logic sign_q, sign_d;
  logic [EW-1:0] exp_q, exp_d, exp_inc;
  logic [MW+1:0] mant_q, mant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ld;
  logic [EW-1:0] pk_exp;
  logic [MW-1:0] pk_frac;
  logic ovf_sel, unf_sel, zero_sel;
  logic [EW+MW:0] pk_r, r_q;
  logic pk_ovf, pk_unf, ovf_q, unf_q;

  assign exp_inc = exp_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    exp_d = exp_q;
    mant_d = mant_q;
    cnt_d = cnt_q;
    ld = 1'b0;
    pk_exp = exp_q;
    pk_frac = mant_q[MW-1:0];
    ovf_sel = 1'b0;
    unf_sel = 1'b0;
    zero_sel = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          sign_d = IN_SIGN;
          exp_d = IN_EXP;
          mant_d = IN_MANT;
          cnt_d = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        ld = 1'b1;
        state_d = S_DONE;
        if (exp_q == EMAX) begin
          ovf_sel = 1'b1;
        end else if (mant_q == '0) begin
          zero_sel = 1'b1;
        end else if (mant_q[MW+1]) begin
          // carry: one right shift, lsb dropped
          pk_exp = exp_inc;
          pk_frac = mant_q[MW:1];
          ovf_sel = (exp_inc == EMAX);
        end else if (mant_q[MW]) begin
          ld = 1'b1;
        end else if (exp_q <= EW'(1) ||
                     cnt_q == CNT_LIM) begin
          unf_sel = 1'b1;
        end else begin
          ld = 1'b0;
          state_d = S_NORM;
          mant_d = mant_q << 1;
          exp_d = exp_q - 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  f32_pack #(
    .EW(EW),
    .MW(MW)
  ) u_pack (
    .sign_i    (sign_q),
    .exp_i     (pk_exp),
    .frac_i    (pk_frac),
    .ovf_sel_i (ovf_sel),
    .unf_sel_i (unf_sel),
    .zero_sel_i(zero_sel),
    .r_o       (pk_r),
    .ovf_o     (pk_ovf),
    .unf_o     (pk_unf)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sign_q <= 1'b0;
      exp_q <= '0;
      mant_q <= '0;
      cnt_q <= '0;
      r_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      mant_q <= mant_d;
      cnt_q <= cnt_d;
      if (ld) begin
        r_q <= pk_r;
        ovf_q <= pk_ovf;
        unf_q <= pk_unf;
      end
    end
  end

  assign IN_READY = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign R = r_q;
  assign OVERFLOW = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_f32_normalizer.sv
// Self-checking bench for f32_normalizer: leading-one reference model,
// queue scoreboard, directed cases, backpressure, reset, random traffic.
module tb_f32_normalizer;

  logic CLK = 1'b0;
  logic RST_N;
  logic IN_VALID;
  logic IN_READY;
  logic IN_SIGN;
  logic [7:0] IN_EXP;
  logic [24:0] IN_MANT;
  logic OUT_VALID;
  logic OUT_READY;
  logic [31:0] R;
  logic OVERFLOW;
  logic UNDERFLOW;

  f32_normalizer dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_SIGN  (IN_SIGN),
    .IN_EXP   (IN_EXP),
    .IN_MANT  (IN_MANT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .R        (R),
    .OVERFLOW (OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] r;
    logic o;
    logic u;
    int k;
    int acc;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit started = 0;
  bit rmode = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, req, $time);
    end
  endtask

  // Reference: locate the leading one, then decide how many left shifts
  // the exponent can afford before it runs out.
  function automatic exp_t model(input logic s, input logic [7:0] e,
                                 input logic [24:0] m);
    exp_t x;
    int p;
    int d;
    int ne;
    logic [24:0] mm;
    x.r = 0;
    x.o = 0;
    x.u = 0;
    x.k = 0;
    x.acc = 0;
    p = 0;
    for (int i = 0; i < 24; i++) if (m[i]) p = i;
    d = 23 - p;
    ne = int'(e) + 1;
    mm = m << d;
    if (e == 8'hFF) begin
      x.r = {s, 8'hFF, 23'h0};
      x.o = 1;
    end else if (m == 0) begin
      x.r = 0;
    end else if (m[24]) begin
      if (ne == 255) begin
        x.r = {s, 8'hFF, 23'h0};
        x.o = 1;
      end else begin
        x.r = {s, 8'(ne), m[23:1]};
      end
    end else if (d == 0) begin
      x.r = {s, e, m[22:0]};
    end else if (int'(e) >= d + 1) begin
      x.r = {s, 8'(int'(e) - d), mm[22:0]};
      x.k = d;
    end else begin
      x.k = (e > 1) ? int'(e) - 1 : 0;
      x.u = 1;
      x.r = {s, 31'h0};
    end
    return x;
  endfunction

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      q.delete();
      started = 0;
    end else begin
      chk("valid_ready_excl", 64'(OUT_VALID & IN_READY), 0);
      if (OUT_VALID) begin
        chk("out_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("R", 64'(R), 64'(q[0].r));
          chk("OVERFLOW", 64'(OVERFLOW), 64'(q[0].o));
          chk("UNDERFLOW", 64'(UNDERFLOW), 64'(q[0].u));
          if (!started) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(2 + q[0].k));
            started = 1;
          end
          if (OUT_READY) begin
            void'(q.pop_front());
            started = 0;
          end
        end
      end else if (q.size() != 0 && !started &&
                   (cyc - q[0].acc) > 2 + q[0].k) begin
        chk("latency_timeout", 64'(cyc - q[0].acc), 64'(2 + q[0].k));
        void'(q.pop_front());
      end
      if (IN_VALID && IN_READY) begin
        exp_t x;
        x = model(IN_SIGN, IN_EXP, IN_MANT);
        x.acc = cyc;
        q.push_back(x);
      end
    end
  end

  always @(posedge CLK) begin
    if (rmode) begin
      #1;
      OUT_READY = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic s, input logic [7:0] e,
                      input logic [24:0] m);
    int n;
    n = 0;
    @(posedge CLK);
    #1;
    IN_VALID = 1;
    IN_SIGN = s;
    IN_EXP = e;
    IN_MANT = m;
    @(negedge CLK);
    while (!IN_READY && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_ready", 64'(IN_READY), 1);
    @(posedge CLK);
    #1;
    IN_VALID = 0;
    IN_SIGN = 1'($urandom);
    IN_EXP = 8'($urandom);
    IN_MANT = 25'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge CLK);
    while ((q.size() != 0 || !IN_READY) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 64'(q.size() == 0 && IN_READY), 1);
  endtask

  initial begin
    exp_t m;
    logic [31:0] r0;
    int n;
    int p;
    logic [7:0] e;
    logic [24:0] mt;

    RST_N = 0;
    IN_VALID = 0;
    IN_SIGN = 0;
    IN_EXP = 0;
    IN_MANT = 0;
    OUT_READY = 0;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 64'(IN_READY), 1);
    chk("rst_out_valid", 64'(OUT_VALID), 0);
    chk("rst_R", 64'(R), 0);
    chk("rst_ovf", 64'(OVERFLOW), 0);
    chk("rst_unf", 64'(UNDERFLOW), 0);
    @(posedge CLK);
    #1;
    RST_N = 1;

    m = model(0, 8'h7F, 25'h0800000);
    chk("pin_one_r", 64'(m.r), 64'h3F800000);
    chk("pin_one_k", 64'(m.k), 0);
    m = model(0, 8'h7F, 25'h1000000);
    chk("pin_two_r", 64'(m.r), 64'h40000000);
    m = model(0, 8'h80, 25'h0200000);
    chk("pin_half_r", 64'(m.r), 64'h3F000000);
    chk("pin_half_k", 64'(m.k), 2);
    m = model(1, 8'hFE, 25'h1000000);
    chk("pin_ovf_r", 64'({m.r, m.o}), 64'({32'hFF800000, 1'b1}));
    m = model(0, 8'h02, 25'h0000001);
    chk("pin_unf_r", 64'({m.r, m.u}), 64'({32'h0, 1'b1}));
    chk("pin_unf_k", 64'(m.k), 1);
    m = model(1, 8'h02, 25'h0);
    chk("pin_zero_r", 64'({m.r, m.o, m.u}), 0);

    OUT_READY = 1;
    send(0, 8'h7F, 25'h0800000);
    drain();
    send(0, 8'h7F, 25'h1000000);
    drain();
    send(0, 8'h80, 25'h0200000);
    drain();
    send(1, 8'hFE, 25'h1000000);
    drain();
    send(0, 8'h02, 25'h0000001);
    drain();
    send(1, 8'h02, 25'h0);
    drain();
    send(0, 8'hFF, 25'h0800000);
    drain();
    send(1, 8'h00, 25'h0000010);
    drain();

    OUT_READY = 0;
    send(0, 8'h90, 25'h0C00000);
    IN_VALID = 1;
    IN_SIGN = 1;
    IN_EXP = 8'h85;
    IN_MANT = 25'h0012345;
    n = 0;
    @(negedge CLK);
    while (!OUT_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_valid", 64'(OUT_VALID), 1);
    r0 = R;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_ready_low", 64'(IN_READY), 0);
      chk("bp_r_stable", 64'(R), 64'(r0));
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1;
    @(negedge CLK);
    chk("hs_no_accept", 64'(IN_READY), 0);
    @(negedge CLK);
    chk("hs_then_idle", 64'(IN_READY), 1);
    @(posedge CLK);
    #1;
    IN_VALID = 0;
    drain();

    send(0, 8'h80, 25'h0000001);
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 0;
    @(negedge CLK);
    chk("rst_norm_ready", 64'(IN_READY), 1);
    chk("rst_norm_valid", 64'(OUT_VALID), 0);
    @(posedge CLK);
    #1;
    RST_N = 1;
    @(negedge CLK);
    chk("post_rst_ready", 64'(IN_READY), 1);
    repeat (30) begin
      @(negedge CLK);
      chk("post_rst_no_out", 64'(OUT_VALID), 0);
    end

    rmode = 1;
    for (int t = 0; t < 300; t++) begin
      p = $urandom_range(0, 25);
      mt = 25'($urandom) & ((25'h1 << p) - 25'h1);
      mt = (p == 25) ? 25'h0 : (mt | (25'h1 << p));
      case ($urandom_range(0, 3))
        0: e = 8'($urandom_range(0, 3));
        1: e = 8'($urandom_range(252, 255));
        default: e = 8'($urandom);
      endcase
      send(1'($urandom), e, mt);
    end
    rmode = 0;
    @(posedge CLK);
    #2;
    OUT_READY = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
